// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-producer FIFOs (ALU, load/store) feeding one registered CDB broadcast.
// Define CDB_ARB_ALU_PRIO_EN for fixed ALU priority; the default is round-robin.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  refresh_rob_cdb_in,
  input  logic                  rdy_a_in,
  input  logic [DATA_WIDTH-1:0] result_a_in,
  input  logic [ROB_WIDTH-1:0]  rob_id_a_in,
  output logic                  full_a_out,
  input  logic                  rdy_ls_in,
  input  logic [DATA_WIDTH-1:0] result_ls_in,
  input  logic [ROB_WIDTH-1:0]  rob_id_ls_in,
  output logic                  full_ls_out,
  output logic                  rdy_cdb_out,
  output logic [DATA_WIDTH-1:0] result_cdb_out,
  output logic [ROB_WIDTH-1:0]  rob_id_cdb_out,
  output logic                  src_cdb_out
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LS = 1'b1} src_t;

  localparam logic [PTR_WIDTH:0]   DEPTH   = (PTR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0]   CNT_ONE = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

  logic                  take;
  logic                  flush;
  logic                  grant_valid;
  src_t                  gsel;
  logic [1:0]            nonempty;
  logic [1:0]            full;
  logic                  push_req [2];
  logic [DATA_WIDTH-1:0] in_data  [2];
  logic [ROB_WIDTH-1:0]  in_tag   [2];
  logic [DATA_WIDTH-1:0] head_data[2];
  logic [ROB_WIDTH-1:0]  head_tag [2];

  assign flush = rdy_in & refresh_rob_cdb_in;
  assign take  = rdy_in & ~refresh_rob_cdb_in;

  assign push_req[0] = rdy_a_in;
  assign in_data[0]  = result_a_in;
  assign in_tag[0]   = rob_id_a_in;
  assign push_req[1] = rdy_ls_in;
  assign in_data[1]  = result_ls_in;
  assign in_tag[1]   = rob_id_ls_in;

  assign full_a_out  = full[0];
  assign full_ls_out = full[1];

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [ROB_WIDTH-1:0]  mem_tag  [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  head;
    logic [PTR_WIDTH-1:0]  tail;
    logic [PTR_WIDTH:0]    count;
    logic                  push;
    logic                  pop;

    // Fullness uses the pre-edge count, so a push while full is lost even if this edge pops.
    assign push = take & push_req[s] & (count != DEPTH) & (in_tag[s] != '0);
    assign pop  = take & grant_valid & (gsel == src_t'(s));

    assign full[s]      = (count == DEPTH);
    assign nonempty[s]  = (count != '0);
    assign head_data[s] = mem_data[head];
    assign head_tag[s]  = mem_tag[head];

    always_ff @(posedge clk_in) begin
      if (push) begin
        mem_data[tail] <= in_data[s];
        mem_tag[tail]  <= in_tag[s];
      end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_ONE;
        if (pop)  head <= head + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: ;
        endcase
      end
    end
  end

`ifndef CDB_ARB_ALU_PRIO_EN
  src_t last_grant;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                last_grant <= SRC_LS;
    else if (take && grant_valid) last_grant <= gsel;
  end
`endif

  always_comb begin
    grant_valid = nonempty[0] | nonempty[1];
    gsel        = SRC_ALU;
    if (nonempty[0] && nonempty[1]) begin
`ifdef CDB_ARB_ALU_PRIO_EN
      gsel = SRC_ALU;
`else
      gsel = (last_grant == SRC_LS) ? SRC_ALU : SRC_LS;
`endif
    end else if (!nonempty[0]) begin
      gsel = SRC_LS;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdy_cdb_out    <= 1'b0;
      result_cdb_out <= '0;
      rob_id_cdb_out <= '0;
      src_cdb_out    <= SRC_ALU;
    end else if (rdy_in) begin
      if (refresh_rob_cdb_in) begin
        rdy_cdb_out <= 1'b0;
      end else if (grant_valid) begin
        rdy_cdb_out    <= 1'b1;
        result_cdb_out <= head_data[gsel];
        rob_id_cdb_out <= head_tag[gsel];
        src_cdb_out    <= gsel;
      end else begin
        rdy_cdb_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic against a queue model.
// Honours CDB_ARB_ALU_PRIO_EN when the design is built with it.
module tb_cdb_arbiter;

  localparam int DW    = 32;
  localparam int RW    = 4;
  localparam int DEPTH = 4;
`ifdef CDB_ARB_ALU_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          rdy_in = 1'b1;
  logic          refresh_rob_cdb_in = 1'b0;
  logic          rdy_a_in = 1'b0;
  logic [DW-1:0] result_a_in = '0;
  logic [RW-1:0] rob_id_a_in = '0;
  logic          full_a_out;
  logic          rdy_ls_in = 1'b0;
  logic [DW-1:0] result_ls_in = '0;
  logic [RW-1:0] rob_id_ls_in = '0;
  logic          full_ls_out;
  logic          rdy_cdb_out;
  logic [DW-1:0] result_cdb_out;
  logic [RW-1:0] rob_id_cdb_out;
  logic          src_cdb_out;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(
    .FIFO_DEPTH(DEPTH),
    .PTR_WIDTH (2),
    .DATA_WIDTH(DW),
    .ROB_WIDTH (RW)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .rdy_in            (rdy_in),
    .refresh_rob_cdb_in(refresh_rob_cdb_in),
    .rdy_a_in          (rdy_a_in),
    .result_a_in       (result_a_in),
    .rob_id_a_in       (rob_id_a_in),
    .full_a_out        (full_a_out),
    .rdy_ls_in         (rdy_ls_in),
    .result_ls_in      (result_ls_in),
    .rob_id_ls_in      (rob_id_ls_in),
    .full_ls_out       (full_ls_out),
    .rdy_cdb_out       (rdy_cdb_out),
    .result_cdb_out    (result_cdb_out),
    .rob_id_cdb_out    (rob_id_cdb_out),
    .src_cdb_out       (src_cdb_out)
  );

  typedef struct {
    logic [RW-1:0] tag;
    logic [DW-1:0] dat;
  } ent_t;

  ent_t          qa[$];
  ent_t          qls[$];
  bit            m_last;   // 1: load/store was granted last
  logic          exp_rdy;
  logic          exp_src;
  logic [RW-1:0] exp_tag;
  logic [DW-1:0] exp_dat;
  int            ncmp = 0;
  int            nfail = 0;

  function automatic void model_reset();
    qa.delete();
    qls.delete();
    m_last  = 1'b1;
    exp_rdy = 1'b0;
    exp_src = 1'b0;
    exp_tag = '0;
    exp_dat = '0;
  endfunction

  // One clock edge of the reference behaviour, using the inputs as they stand at the edge.
  function automatic void model_edge();
    int   na;
    int   nl;
    ent_t e;
    bit   pick_a;
    na = qa.size();
    nl = qls.size();
    if (!rdy_in) return;
    if (refresh_rob_cdb_in) begin
      qa.delete();
      qls.delete();
      exp_rdy = 1'b0;
      return;
    end
    if (na == 0 && nl == 0) begin
      exp_rdy = 1'b0;
    end else begin
      pick_a = (na > 0) && (nl == 0 || PRIO || m_last);
      if (pick_a) begin
        e = qa.pop_front();
        exp_src = 1'b0;
      end else begin
        e = qls.pop_front();
        exp_src = 1'b1;
      end
      m_last  = exp_src;
      exp_rdy = 1'b1;
      exp_tag = e.tag;
      exp_dat = e.dat;
    end
    if (rdy_a_in && rob_id_a_in != 0 && na < DEPTH) qa.push_back('{rob_id_a_in, result_a_in});
    if (rdy_ls_in && rob_id_ls_in != 0 && nl < DEPTH) qls.push_back('{rob_id_ls_in, result_ls_in});
  endfunction

  function automatic logic [DW+RW+3:0] obs_vec();
    return {rdy_cdb_out, full_a_out, full_ls_out,
            rdy_cdb_out ? {src_cdb_out, rob_id_cdb_out, result_cdb_out} : {(DW+RW+1){1'b0}}};
  endfunction

  function automatic logic [DW+RW+3:0] exp_vec();
    return {exp_rdy, (qa.size() == DEPTH), (qls.size() == DEPTH),
            exp_rdy ? {exp_src, exp_tag, exp_dat} : {(DW+RW+1){1'b0}}};
  endfunction

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    rdy_a_in           = 1'b0;
    rdy_ls_in          = 1'b0;
    refresh_rob_cdb_in = 1'b0;
  endtask

  task automatic set_a(input logic [RW-1:0] t, input logic [DW-1:0] d);
    rdy_a_in    = 1'b1;
    rob_id_a_in = t;
    result_a_in = d;
  endtask

  task automatic set_ls(input logic [RW-1:0] t, input logic [DW-1:0] d);
    rdy_ls_in    = 1'b1;
    rob_id_ls_in = t;
    result_ls_in = d;
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_n_in           = 1'b0;
    rdy_in             = 1'b1;
    rdy_a_in           = 1'b0;
    rdy_ls_in          = 1'b0;
    refresh_rob_cdb_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    ncmp++;
    if ({rdy_cdb_out, src_cdb_out, rob_id_cdb_out, result_cdb_out, full_a_out, full_ls_out} !== '0) begin
      nfail++;
      $display("FAIL reset_values: got rdy=%b src=%b tag=%h data=%h fa=%b fl=%b want all 0",
               rdy_cdb_out, src_cdb_out, rob_id_cdb_out, result_cdb_out, full_a_out, full_ls_out);
    end
    step();
    ncmp++;
    if (obs_vec() !== exp_vec()) begin
      nfail++;
      $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single_push();
    apply_reset();
    set_a(4'd3, 32'h11);
    step();
    ncmp++;
    if (rdy_cdb_out !== 1'b0) begin
      nfail++;
      $display("FAIL single_latency: got rdy=%b want 0", rdy_cdb_out);
    end
    step();
    ncmp++;
    if ({rdy_cdb_out, src_cdb_out, rob_id_cdb_out, result_cdb_out} !== {1'b1, 1'b0, 4'd3, 32'h11}) begin
      nfail++;
      $display("FAIL single_bcast: got rdy=%b src=%b tag=%h data=%h want 1 0 3 00000011",
               rdy_cdb_out, src_cdb_out, rob_id_cdb_out, result_cdb_out);
    end
    step();
    ncmp++;
    if (obs_vec() !== exp_vec() || rdy_cdb_out !== 1'b0) begin
      nfail++;
      $display("FAIL single_once: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_alternation();
    int got[$];
    int want[6];
    want = PRIO ? '{1, 1, 1, 2, 2, 2} : '{1, 2, 1, 2, 1, 2};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 3) begin
        set_a(4'd1, $urandom());
        set_ls(4'd2, $urandom());
      end
      step();
      ncmp++;
      if (obs_vec() !== exp_vec()) begin
        nfail++;
        $display("FAIL alternation_c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (rdy_cdb_out === 1'b1) got.push_back(int'(rob_id_cdb_out));
    end
    ncmp++;
    if (got.size() != 6) begin
      nfail++;
      $display("FAIL alternation_count: got %0d broadcasts want 6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        ncmp++;
        if (got[i] != want[i]) begin
          nfail++;
          $display("FAIL alternation_order%0d: got tag %0d want %0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_full();
    bit seen7 = 1'b0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      set_a(RW'(i + 1), $urandom());
      set_ls(RW'(8 + i), $urandom());
      step();
      ncmp++;
      if (obs_vec() !== exp_vec()) begin
        nfail++;
        $display("FAIL fill_c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    ncmp++;
    if (full_ls_out !== 1'b1) begin
      nfail++;
      $display("FAIL full_ls_flag: got %b want 1", full_ls_out);
    end
    set_ls(4'd7, 32'h77);
    for (int i = 0; i < 14; i++) begin
      step();
      ncmp++;
      if (obs_vec() !== exp_vec()) begin
        nfail++;
        $display("FAIL drain_c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (rdy_cdb_out === 1'b1 && src_cdb_out === 1'b1 && rob_id_cdb_out === 4'd7) seen7 = 1'b1;
    end
    ncmp++;
    if (seen7 !== 1'b0) begin
      nfail++;
      $display("FAIL full_drop: got tag 7 broadcast=%b want 0", seen7);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      set_a(RW'(1 + i), $urandom());
      set_ls(RW'(4 + i), $urandom());
      step();
    end
    refresh_rob_cdb_in = 1'b1;
    set_a(4'd9, 32'h99);
    set_ls(4'd10, 32'hAA);
    step();
    ncmp++;
    if ({rdy_cdb_out, full_a_out, full_ls_out} !== 3'b000 || obs_vec() !== exp_vec()) begin
      nfail++;
      $display("FAIL flush_edge: got rdy=%b fa=%b fl=%b want 0 0 0", rdy_cdb_out, full_a_out, full_ls_out);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      ncmp++;
      if (rdy_cdb_out !== 1'b0 || obs_vec() !== exp_vec()) begin
        nfail++;
        $display("FAIL flush_after_c%0d: got rdy=%b tag=%h want rdy 0", i, rdy_cdb_out, rob_id_cdb_out);
      end
    end
  endtask

  task automatic test_tag_zero();
    apply_reset();
    set_a('0, 32'h5A5A);
    set_ls('0, 32'hA5A5);
    for (int i = 0; i < 4; i++) begin
      step();
      ncmp++;
      if (rdy_cdb_out !== 1'b0) begin
        nfail++;
        $display("FAIL tag_zero_c%0d: got rdy=%b tag=%h want rdy 0", i, rdy_cdb_out, rob_id_cdb_out);
      end
    end
  endtask

  task automatic test_rdy_hold();
    apply_reset();
    set_a(4'd5, 32'hA5);
    set_ls(4'd6, 32'h66);
    step();
    step();
    rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_a(4'd9, $urandom());
      refresh_rob_cdb_in = 1'b1;
      step();
      ncmp++;
      if ({rdy_cdb_out, rob_id_cdb_out, result_cdb_out} !== {1'b1, 4'd5, 32'hA5} || obs_vec() !== exp_vec()) begin
        nfail++;
        $display("FAIL hold_c%0d: got rdy=%b tag=%h data=%h want 1 5 000000a5",
                 i, rdy_cdb_out, rob_id_cdb_out, result_cdb_out);
      end
    end
    rdy_in = 1'b1;
    step();
    ncmp++;
    if ({rdy_cdb_out, src_cdb_out, rob_id_cdb_out, result_cdb_out} !== {1'b1, 1'b1, 4'd6, 32'h66}) begin
      nfail++;
      $display("FAIL hold_resume: got rdy=%b src=%b tag=%h data=%h want 1 1 6 00000066",
               rdy_cdb_out, src_cdb_out, rob_id_cdb_out, result_cdb_out);
    end
    step();
    ncmp++;
    if (obs_vec() !== exp_vec()) begin
      nfail++;
      $display("FAIL hold_end: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rdy_in             = ($urandom_range(0, 9) != 0);
      refresh_rob_cdb_in = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 8) set_a(RW'($urandom_range(0, 15)), $urandom());
      if ($urandom_range(0, 9) < 8) set_ls(RW'($urandom_range(0, 15)), $urandom());
      step();
      ncmp++;
      if (obs_vec() !== exp_vec()) begin
        nfail++;
        $display("FAIL random_c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    rdy_in = 1'b1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_a(4'd4, 32'h44);
    step();
    step();
    ncmp++;
    if (obs_vec() !== exp_vec()) begin
      nfail++;
      $display("FAIL async_pre: got %h want %h", obs_vec(), exp_vec());
    end
    #2;
    rst_n_in = 1'b0;
    model_reset();
    #1;
    ncmp++;
    if ({rdy_cdb_out, src_cdb_out, rob_id_cdb_out, result_cdb_out, full_a_out, full_ls_out} !== '0) begin
      nfail++;
      $display("FAIL async_reset: got rdy=%b tag=%h data=%h want all 0 before edge",
               rdy_cdb_out, rob_id_cdb_out, result_cdb_out);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step();
    ncmp++;
    if (obs_vec() !== exp_vec()) begin
      nfail++;
      $display("FAIL async_after: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_push();
    test_alternation();
    test_full();
    test_flush();
    test_tag_zero();
    test_rdy_hold();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
